paddle_ai_driver: RTL

//  Computer-controlled opponent: drives the up/down request inputs of a paddle

---
 rtl/paddle_ai_driver.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/paddle_ai_driver.sv
// Computer opponent for the right paddle: steers the paddle tracker's
// up/down requests toward the ball with a reaction delay and a deadband.
module paddle_ai_driver #(
    parameter int Y_RES           = 480,
    parameter int DEADBAND        = 8,
    parameter int REACTION_FRAMES = 4,
    parameter int RETARGET_FRAMES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               game_on,
    input  logic               frame_tick,
    input  logic               ball_toward,
    input  logic signed [31:0] ball_y,
    input  logic signed [31:0] paddle_y,
    output logic               up,
    output logic               down,
    output logic [1:0]         ai_state
);

    localparam int MAXF = (REACTION_FRAMES > RETARGET_FRAMES) ?
                          REACTION_FRAMES : RETARGET_FRAMES;
    localparam int CW   = (MAXF > 0) ? $clog2(MAXF + 1) : 1;

    localparam logic signed [31:0] YR  = 32'(Y_RES);
    localparam logic signed [31:0] MID = 32'(Y_RES / 2);
    localparam logic signed [31:0] DB  = 32'(DEADBAND);

    localparam logic [CW:0] REACT_N  = (CW + 1)'(REACTION_FRAMES);
    localparam logic [CW:0] RETGT_N  = (CW + 1)'(RETARGET_FRAMES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        TRACK  = 2'd2,
        CENTER = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic signed [31:0]  r_target;
    logic signed [31:0]  w_target_nxt;
    logic [CW-1:0]       r_cnt;
    logic [CW-1:0]       w_cnt_nxt;
    logic                r_toward_d;
    logic                r_up;
    logic                r_dn;
    logic                w_up_nxt;
    logic                w_dn_nxt;
    logic signed [31:0]  w_clamp;
    logic signed [31:0]  w_err;
    logic [CW:0]         w_cnt_inc;
    logic                w_req_up;
    logic                w_req_dn;

    assign w_clamp   = (ball_y < 0)  ? 32'sd0 :
                       (ball_y > YR) ? YR     : ball_y;
    assign w_err     = r_target - paddle_y;
    assign w_req_up  = (w_err > DB);
    assign w_req_dn  = (w_err < -DB);
    assign w_cnt_inc = {1'b0, r_cnt} + (CW + 1)'(1);

    // Priority: rally over, ball leaving, ball turning back, then per-state rules.
    always_comb begin
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_cnt_nxt    = r_cnt;
        w_up_nxt     = 1'b0;
        w_dn_nxt     = 1'b0;
        if (!game_on) begin
            w_state_nxt  = IDLE;
            w_target_nxt = MID;
            w_cnt_nxt    = '0;
        end else if ((r_state == WAIT || r_state == TRACK) && !ball_toward) begin
            w_state_nxt  = CENTER;
            w_target_nxt = MID;
            w_cnt_nxt    = '0;
        end else if (r_state == CENTER && ball_toward && !r_toward_d) begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_cnt_nxt = '0;
                    if (ball_toward) begin
                        w_state_nxt = WAIT;
                    end else begin
                        w_state_nxt  = CENTER;
                        w_target_nxt = MID;
                    end
                end
                WAIT: begin
                    if (REACTION_FRAMES == 0) begin
                        w_state_nxt  = TRACK;
                        w_target_nxt = w_clamp;
                        w_cnt_nxt    = '0;
                    end else if (frame_tick) begin
                        if (w_cnt_inc == REACT_N) begin
                            w_state_nxt  = TRACK;
                            w_target_nxt = w_clamp;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc[CW-1:0];
                        end
                    end
                end
                TRACK: begin
                    w_up_nxt = w_req_up;
                    w_dn_nxt = w_req_dn;
                    if (frame_tick) begin
                        if (w_cnt_inc >= RETGT_N) begin
                            w_target_nxt = w_clamp;
                            w_cnt_nxt    = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc[CW-1:0];
                        end
                    end
                end
                CENTER: begin
                    w_up_nxt = w_req_up;
                    w_dn_nxt = w_req_dn;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_target   <= MID;
            r_cnt      <= '0;
            r_toward_d <= 1'b0;
            r_up       <= 1'b0;
            r_dn       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_target   <= w_target_nxt;
            r_cnt      <= w_cnt_nxt;
            r_toward_d <= ball_toward;
            r_up       <= w_up_nxt;
            r_dn       <= w_dn_nxt;
        end
    end

    assign up       = r_up;
    assign down     = r_dn;
    assign ai_state = r_state;

endmodule
